// File: rtl/instruction_fetch_unit_if.sv
// Fetch-stage bundle: instruction memory port, hazard controls and IF/ID pipeline outputs.
interface instruction_fetch_unit_if;
  logic [31:0] PC;
  logic [31:0] instruction;
  logic        stall;
  logic        flush;
  logic        redirect;
  logic [31:0] redirect_target;
  logic [31:0] if_id_instruction;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic        fault;
  logic [31:0] fetch_count;

  modport master (
    output PC, if_id_instruction, if_id_pc4, if_id_valid, fault, fetch_count,
    input  instruction, stall, flush, redirect, redirect_target
  );

  modport slave (
    input  PC, if_id_instruction, if_id_pc4, if_id_valid, fault, fetch_count,
    output instruction, stall, flush, redirect, redirect_target
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// IF stage: owns the PC, captures fetched words into IF/ID, handles stall/flush/redirect
// and latches a sticky fault on any illegal fetch address.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'd0,
  parameter int unsigned MEM_BYTES = 16384
) (
  input  logic                     clk,
  input  logic                     rst,
  instruction_fetch_unit_if.master bus
);

  localparam logic [31:0] LAST_PC = 32'(MEM_BYTES - 4);

  typedef enum logic {RUN, FAULT} state_t;

  state_t      state;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] pc4_q;
  logic        valid_q;
  logic        fault_q;
  logic [31:0] count_q;

  logic [32:0] pc_sum;
  logic [31:0] pc4;
  logic        pc4_legal;
  logic        target_legal;

  // Sequential successor is illegal if misaligned, past the last word, or wrapped.
  always_comb begin
    pc_sum       = {1'b0, pc_q} + 33'd4;
    pc4          = pc_sum[31:0];
    pc4_legal    = !pc_sum[32] && (pc4[1:0] == 2'b00) && (pc4 <= LAST_PC);
    target_legal = (bus.redirect_target[1:0] == 2'b00) && (bus.redirect_target <= LAST_PC);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RUN;
      pc_q    <= RESET_PC;
      instr_q <= 32'd0;
      pc4_q   <= 32'd0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      count_q <= 32'd0;
    end else begin
      case (state)
        RUN: begin
          if (bus.redirect) begin
            // Wrong-path word fetched this cycle is dropped.
            instr_q <= 32'd0;
            pc4_q   <= 32'd0;
            valid_q <= 1'b0;
            if (target_legal) begin
              pc_q <= bus.redirect_target;
            end else begin
              state   <= FAULT;
              fault_q <= 1'b1;
            end
          end else if (bus.stall) begin
            if (bus.flush) begin
              instr_q <= 32'd0;
              pc4_q   <= 32'd0;
              valid_q <= 1'b0;
            end
          end else if (bus.flush) begin
            instr_q <= 32'd0;
            pc4_q   <= 32'd0;
            valid_q <= 1'b0;
            if (pc4_legal) begin
              pc_q <= pc4;
            end else begin
              state   <= FAULT;
              fault_q <= 1'b1;
            end
          end else begin
            // Captured word stays valid even when its successor address faults.
            instr_q <= bus.instruction;
            pc4_q   <= pc4;
            valid_q <= 1'b1;
            count_q <= count_q + 32'd1;
            if (pc4_legal) begin
              pc_q <= pc4;
            end else begin
              state   <= FAULT;
              fault_q <= 1'b1;
            end
          end
        end
        FAULT: begin
          instr_q <= 32'd0;
          pc4_q   <= 32'd0;
          valid_q <= 1'b0;
          fault_q <= 1'b1;
        end
        default: begin
          state   <= FAULT;
          fault_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.PC                = pc_q;
  assign bus.if_id_instruction = instr_q;
  assign bus.if_id_pc4         = pc4_q;
  assign bus.if_id_valid       = valid_q;
  assign bus.fault             = fault_q;
  assign bus.fetch_count       = count_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: scoreboard of delivered IF/ID words plus directed PC/state checks.
module tb_instruction_fetch_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_b = 1'b1;

  int total = 0;
  int bad = 0;

  logic [63:0] sb_q[$];
  logic [31:0] prev_count = 32'd0;

  always #5 clk = ~clk;

  instruction_fetch_unit_if ifa();
  instruction_fetch_unit_if ifb();

  // Memory model: two preloaded words, elsewhere a tag plus the low address bits.
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    if (addr == 32'd700) return 32'h48080000;
    if (addr == 32'd704) return 32'h00000000;
    return {16'hC0DE, addr[15:0]};
  endfunction

  assign ifa.instruction = mem_word(ifa.PC);
  assign ifb.instruction = mem_word(ifb.PC);

  instruction_fetch_unit #(.RESET_PC(32'd700), .MEM_BYTES(16384)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa)
  );

  instruction_fetch_unit #(.RESET_PC(32'd16380), .MEM_BYTES(16384)) dut_b (
    .clk(clk), .rst(rst_b), .bus(ifb)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every new delivery (fetch_count step) must match the next queued expectation.
  always @(negedge clk) begin
    if (!rst && ifa.fetch_count == prev_count + 32'd1) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected: got instr 0x%08h pc4 0x%08h with no expectation queued",
                 ifa.if_id_instruction, ifa.if_id_pc4);
      end else begin
        logic [63:0] e;
        e = sb_q.pop_front();
        chk("sb_instr", ifa.if_id_instruction, e[63:32]);
        chk("sb_pc4", ifa.if_id_pc4, e[31:0]);
        chk("sb_valid", 32'(ifa.if_id_valid), 32'd1);
      end
    end
    prev_count = ifa.fetch_count;
  end

  task automatic cyc(input logic s, input logic f, input logic r, input logic [31:0] t);
    ifa.stall = s;
    ifa.flush = f;
    ifa.redirect = r;
    ifa.redirect_target = t;
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] instr, input logic [31:0] pc4);
    sb_q.push_back({instr, pc4});
    cyc(1'b0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic chk_state(input string name, input logic [31:0] pc, input logic [31:0] cnt,
                           input logic flt);
    chk({name, "_pc"}, ifa.PC, pc);
    chk({name, "_count"}, ifa.fetch_count, cnt);
    chk({name, "_fault"}, 32'(ifa.fault), 32'(flt));
  endtask

  task automatic chk_bubble(input string name);
    chk({name, "_bub_instr"}, ifa.if_id_instruction, 32'd0);
    chk({name, "_bub_pc4"}, ifa.if_id_pc4, 32'd0);
    chk({name, "_bub_valid"}, 32'(ifa.if_id_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ifa.stall = 1'b0; ifa.flush = 1'b0; ifa.redirect = 1'b0; ifa.redirect_target = 32'd0;
    ifb.stall = 1'b0; ifb.flush = 1'b0; ifb.redirect = 1'b0; ifb.redirect_target = 32'd0;

    repeat (2) @(posedge clk);
    #1;
    chk_state("reset", 32'd700, 32'd0, 1'b0);
    chk_bubble("reset");
    rst = 1'b0;

    // Sequential fetch from 700.
    fetch(32'h48080000, 32'd704);
    chk_state("seq0", 32'd704, 32'd1, 1'b0);
    chk("seq0_valid", 32'(ifa.if_id_valid), 32'd1);
    fetch(32'h00000000, 32'd708);
    chk_state("seq1", 32'd708, 32'd2, 1'b0);
    fetch(32'hC0DE02C4, 32'd712);
    chk_state("seq2", 32'd712, 32'd3, 1'b0);

    // Two-cycle stall at 712: everything holds.
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 32'd0);
      chk_state("stall", 32'd712, 32'd3, 1'b0);
      chk("stall_instr", ifa.if_id_instruction, 32'hC0DE02C4);
      chk("stall_pc4", ifa.if_id_pc4, 32'd712);
      chk("stall_valid", 32'(ifa.if_id_valid), 32'd1);
    end
    fetch(32'hC0DE02C8, 32'd716);
    chk_state("resume", 32'd716, 32'd4, 1'b0);
    fetch(32'hC0DE02CC, 32'd720);
    fetch(32'hC0DE02D0, 32'd724);
    fetch(32'hC0DE02D4, 32'd728);
    chk_state("pre_redir", 32'd728, 32'd7, 1'b0);

    // Redirect to 232: one bubble, wrong-path word at 728 not counted.
    cyc(1'b0, 1'b0, 1'b1, 32'd232);
    chk_state("redir", 32'd232, 32'd7, 1'b0);
    chk_bubble("redir");
    fetch(32'hC0DE00E8, 32'd236);
    chk_state("redir_tgt", 32'd236, 32'd8, 1'b0);

    // Redirect beats stall.
    cyc(1'b1, 1'b0, 1'b1, 32'd400);
    chk_state("redir_stall", 32'd400, 32'd8, 1'b0);
    chk_bubble("redir_stall");
    fetch(32'hC0DE0190, 32'd404);
    chk_state("after_rs", 32'd404, 32'd9, 1'b0);

    // Flush with stall: PC holds, bubble.
    cyc(1'b1, 1'b1, 1'b0, 32'd0);
    chk_state("flush_stall", 32'd404, 32'd9, 1'b0);
    chk_bubble("flush_stall");
    // Flush alone: PC advances, bubble.
    cyc(1'b0, 1'b1, 1'b0, 32'd0);
    chk_state("flush", 32'd408, 32'd9, 1'b0);
    chk_bubble("flush");
    fetch(32'hC0DE0198, 32'd412);
    chk_state("after_flush", 32'd412, 32'd10, 1'b0);

    // Misaligned redirect target traps.
    cyc(1'b0, 1'b0, 1'b1, 32'h00000102);
    chk_state("bad_align", 32'd412, 32'd10, 1'b1);
    chk_bubble("bad_align");
    cyc(1'b0, 1'b0, 1'b1, 32'd8);
    chk_state("fault_hold", 32'd412, 32'd10, 1'b1);
    chk_bubble("fault_hold");
    cyc(1'b0, 1'b0, 1'b0, 32'd0);
    chk_state("fault_hold2", 32'd412, 32'd10, 1'b1);

    // Asynchronous reset mid-cycle.
    #2;
    rst = 1'b1;
    #1;
    chk_state("async_rst", 32'd700, 32'd0, 1'b0);
    chk_bubble("async_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    fetch(32'h48080000, 32'd704);
    chk_state("rst_refetch", 32'd704, 32'd1, 1'b0);

    // Out-of-range redirect target traps.
    cyc(1'b0, 1'b0, 1'b1, 32'd16384);
    chk_state("bad_range", 32'd704, 32'd1, 1'b1);
    chk_bubble("bad_range");
    cyc(1'b0, 1'b0, 1'b0, 32'd0);
    chk_state("bad_range2", 32'd704, 32'd1, 1'b1);
    chk_bubble("bad_range2");

    // End of memory: last word delivered, then fault with PC held.
    chk("eom_reset_pc", ifb.PC, 32'd16380);
    rst_b = 1'b0;
    @(posedge clk);
    #1;
    chk("eom_instr", ifb.if_id_instruction, 32'hC0DE3FFC);
    chk("eom_pc4", ifb.if_id_pc4, 32'd16384);
    chk("eom_valid", 32'(ifb.if_id_valid), 32'd1);
    chk("eom_count", ifb.fetch_count, 32'd1);
    chk("eom_fault", 32'(ifb.fault), 32'd1);
    chk("eom_pc", ifb.PC, 32'd16380);
    @(posedge clk);
    #1;
    chk("eom2_valid", 32'(ifb.if_id_valid), 32'd0);
    chk("eom2_instr", ifb.if_id_instruction, 32'd0);
    chk("eom2_count", ifb.fetch_count, 32'd1);
    chk("eom2_pc", ifb.PC, 32'd16380);

    @(negedge clk);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

IF stage of the pipelined processor, driving the instruction memory. Owns the PC register and issues `PC` to the byte-addressed, big-endian, combinational-read instruction memory. Captures the returned `instruction` into the IF/ID pipeline register. Handles hazard-unit stalls, flushes, and branch/jump redirects, and traps illegal fetch addresses.

## Interface
Parameters:
- `RESET_PC`, 0: PC value after reset. Must be word-aligned and ≤ `MEM_BYTES`-4.
- `MEM_BYTES`, 16384: instruction memory size in bytes. Legal fetch addresses are 0..`MEM_BYTES`-4.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `PC`  out  32  fetch address to instruction memory, registered.
- `instruction`  in  32  word returned combinationally for `PC`.
- `stall`  in  1  hazard unit: hold PC and IF/ID.
- `flush`  in  1  squash the IF/ID contents.
- `redirect`  in  1  taken branch / jump / jr.
- `redirect_target`  in  32  new PC when `redirect`=1.
- `if_id_instruction`  out  32  IF/ID instruction; 0x00000000 (nop) when a bubble.
- `if_id_pc4`  out  32  IF/ID PC+4 of the captured instruction; 0 when a bubble.
- `if_id_valid`  out  1  IF/ID holds a real instruction.
- `fault`  out  1  sticky illegal-fetch flag.
- `fetch_count`  out  32  count of instructions delivered valid to IF/ID; wraps modulo 2^32.

## Operation
- Two states: RUN and FAULT.
- Reset values: state=RUN, `PC`=`RESET_PC`, `if_id_instruction`=0, `if_id_pc4`=0, `if_id_valid`=0, `fault`=0, `fetch_count`=0.
- Bubble means `if_id_instruction`=0, `if_id_pc4`=0, `if_id_valid`=0.
- "Next PC" is `redirect_target` if `redirect`=1, else `PC`+4. Addition is 32-bit modulo 2^32.
- A next PC is illegal if bits [1:0]≠0, or it is > `MEM_BYTES`-4, or `PC`+4 wrapped.
- RUN, per edge, first match wins:
  - `redirect`=1: IF/ID←bubble. `stall` and `flush` are ignored. If the target is legal, PC←target. Otherwise PC holds and state←FAULT.
  - `stall`=1: PC holds. IF/ID holds, unless `flush`=1, in which case IF/ID←bubble.
  - `flush`=1: IF/ID←bubble. PC advances to PC+4 (or FAULT, per the normal rule).
  - Normal: IF/ID←{`instruction`, PC+4, 1} and `fetch_count`++. If PC+4 is legal, PC←PC+4. Otherwise PC holds and state←FAULT; the instruction just captured stays valid.
- FAULT: `fault`=1, PC holds, IF/ID←bubble every cycle, `fetch_count` holds. All inputs are ignored. Exit only via `rst`.

## Timing
- `PC` is registered. `instruction` is consumed in the same cycle `PC` is presented.
- Latency: an instruction at address A appears on `if_id_*` one edge after `PC`=A.
- Redirect penalty: one bubble. The wrong-path word fetched in the redirect cycle is discarded. The target word is valid in IF/ID two edges after the `redirect` cycle.
- Stall: each held cycle adds one cycle. IF/ID outputs are stable and `fetch_count` is unchanged while held.
- `fault` rises on the edge that enters FAULT. It stays 1 until `rst`.
- Reset mid-operation: all outputs take their reset values immediately (asynchronous), regardless of state. The first fetch after release is `RESET_PC`.
- Simultaneous `redirect` and `stall`: `redirect` wins; the stall is dropped.
- Simultaneous `flush` and `stall`: PC holds and IF/ID←bubble.

## Test plan
- **Reset/sequential fetch.** `RESET_PC`=700, memory preloaded with 0x48080000 at 700 and 0x00000000 at 704. Release `rst`. Required: `PC`=700, 704, 708 on successive edges. After the first edge IF/ID={0x48080000, 704, 1}. `fetch_count` increments by 1 per edge.
- **Stall.** Assert `stall` for 2 cycles while `PC`=712. Required: `PC` stays 712 and IF/ID is unchanged for both cycles. Fetch resumes at 712 with no instruction lost or duplicated.
- **Redirect.** Assert `redirect` with target 232 while `PC`=728. Required: next edge IF/ID is a bubble and `PC`=232. The edge after, IF/ID holds the word at 232 with `if_id_pc4`=236. `fetch_count` skips the discarded word.
- **Priority.** Assert `redirect` and `stall` together: PC takes the target. Assert `flush` and `stall` together: PC holds and IF/ID becomes a bubble.
- **Illegal target.** Redirect to 0x00000102: `fault`=1, `PC` holds, IF/ID is all bubbles. Redirect to 16384: same response. In both cases `fetch_count` freezes until `rst`, after which everything returns to reset values.
- **Sequential end of memory.** `RESET_PC`=16380: word at 16380 is delivered valid, then `fault`=1 and `PC` stays 16380.
